// File: rtl/mem_access_unit_pkg.sv
// Shared constants, size/format codes and FSM encoding for the MEM-stage memory path.
// Access-size decode and alignment helpers are kept here so the top and lane merge agree.
package mem_access_unit_pkg;

    localparam int BYTE_SIZE       = 8;
    localparam int MAX_WAIT_STATES = 7;

    localparam logic [1:0] WR_WORD = 2'd0;
    localparam logic [1:0] WR_HALF = 2'd1;
    localparam logic [1:0] WR_BYTE = 2'd2;

    localparam logic [2:0] RD_WORD  = 3'd0;
    localparam logic [2:0] RD_SHALF = 3'd1;
    localparam logic [2:0] RD_SBYTE = 3'd2;
    localparam logic [2:0] RD_UHALF = 3'd3;
    localparam logic [2:0] RD_UBYTE = 3'd4;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_HALF = 2'd1,
        SZ_BYTE = 2'd2
    } size_t;

    function automatic size_t store_size(input logic [1:0] wr_src);
        case (wr_src)
            WR_HALF: return SZ_HALF;
            WR_BYTE: return SZ_BYTE;
            default: return SZ_WORD;
        endcase
    endfunction

    function automatic size_t load_size(input logic [2:0] rd_src);
        case (rd_src)
            RD_SHALF, RD_UHALF: return SZ_HALF;
            RD_SBYTE, RD_UBYTE: return SZ_BYTE;
            default:            return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input size_t sz, input logic [1:0] off);
        case (sz)
            SZ_HALF: return off[0];
            SZ_WORD: return |off;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// Combinational store merge: overlays the store data onto the old word in the
// addressed little-endian lanes only.
module mem_lane_merge
    import mem_access_unit_pkg::*;
#(
    parameter int IO_BUS_SIZE = 32
) (
    input  logic [IO_BUS_SIZE-1:0] i_old,
    input  logic [IO_BUS_SIZE-1:0] i_data,
    input  logic [1:0]             i_off,
    input  size_t                  i_size,
    output logic [IO_BUS_SIZE-1:0] o_word
);

    localparam int LANES = IO_BUS_SIZE / BYTE_SIZE;

    logic [LANES-1:0]       lane_en;
    logic [IO_BUS_SIZE-1:0] data_rep;

    // Sub-word data is replicated across the word so each enabled lane picks its copy.
    always_comb begin
        lane_en  = '1;
        data_rep = i_data;
        case (i_size)
            SZ_HALF: begin
                lane_en  = LANES'(2'b11) << {i_off[1], 1'b0};
                data_rep = {(IO_BUS_SIZE/16){i_data[15:0]}};
            end
            SZ_BYTE: begin
                lane_en  = LANES'(1'b1) << i_off;
                data_rep = {LANES{i_data[7:0]}};
            end
            default: ;
        endcase
        o_word = i_old;
        for (int b = 0; b < LANES; b++) begin
            if (lane_en[b]) o_word[b*BYTE_SIZE +: BYTE_SIZE] = data_rep[b*BYTE_SIZE +: BYTE_SIZE];
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage memory path with configurable latency: byte-addressed loads/stores,
// sub-word lane writes, misalignment rejection and an IDLE/BUSY stall FSM.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int IO_BUS_SIZE   = 32,
    parameter int MEM_ADDR_SIZE = 5,
    parameter int WAIT_STATES   = 1
) (
    input  logic                                    i_clk,
    input  logic                                    i_reset,
    input  logic                                    i_flush,
    input  logic                                    i_valid,
    input  logic                                    i_mem_wr_rd,
    input  logic [1:0]                              i_mem_wr_src,
    input  logic [2:0]                              i_mem_rd_src,
    input  logic [IO_BUS_SIZE-1:0]                  i_alu_res,
    input  logic [IO_BUS_SIZE-1:0]                  i_bus_b,
    output logic [IO_BUS_SIZE-1:0]                  o_mem_rd,
    output logic                                    o_busy,
    output logic                                    o_done,
    output logic                                    o_misaligned,
    output logic [(2**MEM_ADDR_SIZE)*IO_BUS_SIZE-1:0] o_bus_debug
);

    localparam int DEPTH = 2**MEM_ADDR_SIZE;

    state_t                   state_q;
    logic [2:0]               cnt_q;
    logic                     wr_q;
    size_t                    sz_q;
    logic [2:0]               rd_src_q;
    logic [MEM_ADDR_SIZE-1:0] idx_q;
    logic [1:0]               off_q;
    logic [IO_BUS_SIZE-1:0]   data_q;
    logic [IO_BUS_SIZE-1:0]   mem_q [DEPTH];
    logic [IO_BUS_SIZE-1:0]   mem_rd_q;
    logic                     done_q;
    logic                     mis_q;

    logic [1:0]               req_off;
    logic [MEM_ADDR_SIZE-1:0] req_idx;
    size_t                    req_size;
    logic                     req_mis;
    logic                     unused_addr;

    assign req_off     = i_alu_res[1:0];
    assign req_idx     = i_alu_res[MEM_ADDR_SIZE+1:2];
    assign req_size    = i_mem_wr_rd ? store_size(i_mem_wr_src) : load_size(i_mem_rd_src);
    assign req_mis     = is_misaligned(req_size, req_off);
    assign unused_addr = ^i_alu_res[IO_BUS_SIZE-1:MEM_ADDR_SIZE+2];

    logic [IO_BUS_SIZE-1:0] rd_word;
    logic [7:0]             rd_byte;
    logic [15:0]            rd_half;
    logic [IO_BUS_SIZE-1:0] load_ext;
    logic [IO_BUS_SIZE-1:0] merged;

    assign rd_word = mem_q[idx_q];
    assign rd_byte = rd_word[{off_q, 3'b000} +: 8];
    assign rd_half = rd_word[{off_q[1], 4'b0000} +: 16];

    always_comb begin
        load_ext = rd_word;
        case (rd_src_q)
            RD_SHALF: load_ext = {{(IO_BUS_SIZE-16){rd_half[15]}}, rd_half};
            RD_SBYTE: load_ext = {{(IO_BUS_SIZE-8){rd_byte[7]}}, rd_byte};
            RD_UHALF: load_ext = {{(IO_BUS_SIZE-16){1'b0}}, rd_half};
            RD_UBYTE: load_ext = {{(IO_BUS_SIZE-8){1'b0}}, rd_byte};
            default:  load_ext = rd_word;
        endcase
    end

    mem_lane_merge #(.IO_BUS_SIZE(IO_BUS_SIZE)) u_merge (
        .i_old  (rd_word),
        .i_data (data_q),
        .i_off  (off_q),
        .i_size (sz_q),
        .o_word (merged)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            wr_q     <= 1'b0;
            sz_q     <= SZ_WORD;
            rd_src_q <= '0;
            idx_q    <= '0;
            off_q    <= '0;
            data_q   <= '0;
            mem_rd_q <= '0;
            done_q   <= 1'b0;
            mis_q    <= 1'b0;
            for (int w = 0; w < DEPTH; w++) mem_q[w] <= '0;
        end else if (i_flush) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
            for (int w = 0; w < DEPTH; w++) mem_q[w] <= '0;
        end else begin
            done_q <= 1'b0;
            mis_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_valid) begin
                        // A rejected request is answered next cycle without touching memory.
                        if (req_mis) begin
                            done_q <= 1'b1;
                            mis_q  <= 1'b1;
                        end else begin
                            wr_q     <= i_mem_wr_rd;
                            sz_q     <= req_size;
                            rd_src_q <= i_mem_rd_src;
                            idx_q    <= req_idx;
                            off_q    <= req_off;
                            data_q   <= i_bus_b;
                            cnt_q    <= 3'(WAIT_STATES);
                            state_q  <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (cnt_q != 3'd0) begin
                        cnt_q <= cnt_q - 3'd1;
                    end else begin
                        if (wr_q) mem_q[idx_q] <= merged;
                        else      mem_rd_q     <= load_ext;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_mem_rd     = mem_rd_q;
    assign o_busy       = (state_q == S_BUSY);
    assign o_done       = done_q;
    assign o_misaligned = mis_q;

    for (genvar w = 0; w < DEPTH; w++) begin : g_dbg
        assign o_bus_debug[w*IO_BUS_SIZE +: IO_BUS_SIZE] = mem_q[w];
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-array reference model, expected-response queue
// popped by an independent monitor, plus a zero-wait-state instance for back-to-back traffic.
module tb_mem_access_unit;

    localparam int W     = 32;
    localparam int A     = 5;
    localparam int WS    = 2;
    localparam int DEPTH = 2**A;
    localparam int DBG   = DEPTH*W;

    logic           clk = 1'b0;
    logic           rst, flush;
    logic           valid, wr_rd;
    logic [1:0]     wr_src;
    logic [2:0]     rd_src;
    logic [W-1:0]   addr, bus_b;
    logic [W-1:0]   mem_rd;
    logic           busy, done, mis;
    logic [DBG-1:0] dbg;

    logic           valid_z, wr_rd_z;
    logic [1:0]     wr_src_z;
    logic [2:0]     rd_src_z;
    logic [W-1:0]   addr_z, bus_b_z;
    logic [W-1:0]   mem_rd_z;
    logic           busy_z, done_z, mis_z;
    logic [DBG-1:0] dbg_z;

    always #5 clk = ~clk;

    mem_access_unit #(.IO_BUS_SIZE(W), .MEM_ADDR_SIZE(A), .WAIT_STATES(WS)) dut (
        .i_clk(clk), .i_reset(rst), .i_flush(flush), .i_valid(valid),
        .i_mem_wr_rd(wr_rd), .i_mem_wr_src(wr_src), .i_mem_rd_src(rd_src),
        .i_alu_res(addr), .i_bus_b(bus_b), .o_mem_rd(mem_rd), .o_busy(busy),
        .o_done(done), .o_misaligned(mis), .o_bus_debug(dbg)
    );

    mem_access_unit #(.IO_BUS_SIZE(W), .MEM_ADDR_SIZE(A), .WAIT_STATES(0)) dut_z (
        .i_clk(clk), .i_reset(rst), .i_flush(flush), .i_valid(valid_z),
        .i_mem_wr_rd(wr_rd_z), .i_mem_wr_src(wr_src_z), .i_mem_rd_src(rd_src_z),
        .i_alu_res(addr_z), .i_bus_b(bus_b_z), .o_mem_rd(mem_rd_z), .o_busy(busy_z),
        .o_done(done_z), .o_misaligned(mis_z), .o_bus_debug(dbg_z)
    );

    int             n_checks = 0;
    int             n_errors = 0;
    logic [7:0]     mem_m [DEPTH*4];
    logic [W-1:0]   rd_m;
    logic [W:0]     exp_q [$];
    int             done_z_cnt = 0;
    logic [W-1:0]   got_z [$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [DBG-1:0] model_dbg();
        logic [DBG-1:0] v;
        for (int i = 0; i < DEPTH*4; i++) v[i*8 +: 8] = mem_m[i];
        return v;
    endfunction

    task automatic chk_dbg(input string name, input logic [DBG-1:0] got);
        logic [DBG-1:0] e;
        e = model_dbg();
        n_checks++;
        if (got !== e) begin
            int w;
            w = 0;
            for (int i = DEPTH-1; i >= 0; i--) if (got[i*W +: W] !== e[i*W +: W]) w = i;
            n_errors++;
            $display("FAIL %s: word %0d got %h expected %h", name, w, got[w*W +: W], e[w*W +: W]);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH*4; i++) mem_m[i] = 8'h00;
    endtask

    function automatic int size_of(input logic wr, input logic [1:0] ws, input logic [2:0] rs);
        if (wr) return (ws == 2'd1) ? 2 : (ws == 2'd2) ? 1 : 4;
        return (rs == 3'd1 || rs == 3'd3) ? 2 : (rs == 3'd2 || rs == 3'd4) ? 1 : 4;
    endfunction

    task automatic model_access(input logic wr, input logic [1:0] ws, input logic [2:0] rs,
                                input logic [W-1:0] a, input logic [W-1:0] d, output logic m);
        int sz, base;
        logic [W-1:0] v;
        sz   = size_of(wr, ws, rs);
        base = int'(a[6:0]);
        m    = (base % sz) != 0;
        if (!m) begin
            if (wr) begin
                for (int i = 0; i < sz; i++) mem_m[base+i] = d[i*8 +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < sz; i++) v[i*8 +: 8] = mem_m[base+i];
                if (rs == 3'd2 && v[7])  v = v | 32'hFFFF_FF00;
                if (rs == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
                rd_m = v;
            end
        end
    endtask

    // Called at a falling edge; returns at the falling edge where o_done is visible.
    task automatic do_access(input logic wr, input logic [1:0] ws, input logic [2:0] rs,
                             input logic [W-1:0] a, input logic [W-1:0] d,
                             input string tag, input bit intrude);
        logic m;
        int   cyc;
        model_access(wr, ws, rs, a, d, m);
        exp_q.push_back({m, rd_m});
        valid = 1'b1; wr_rd = wr; wr_src = ws; rd_src = rs; addr = a; bus_b = d;
        @(posedge clk);
        #1 valid = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) chk({tag, "_busy"}, busy, !m);
            if (intrude && cyc == 1) begin
                valid = 1'b1; wr_rd = 1'b1; wr_src = 2'd0; addr = a + 32'd4; bus_b = 32'h1234_5678;
            end
            if (cyc == 2) valid = 1'b0;
        end while (!done && cyc < 20);
        chk({tag, "_latency"}, cyc, m ? 1 : WS + 2);
        chk({tag, "_busy_at_done"}, busy, 0);
        chk_dbg({tag, "_dbg"}, dbg);
    endtask

    initial begin
        logic [W:0] e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_done: got done=1 required no pending access");
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_misaligned", mis, e[W]);
                    chk("mon_mem_rd", mem_rd, e[W-1:0]);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (done_z) begin
                done_z_cnt++;
                got_z.push_back(mem_rd_z);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] d6 [3];
        logic [W-1:0] ra, rd;
        rst = 1'b1; flush = 1'b0; valid = 1'b0; wr_rd = 1'b0; wr_src = '0; rd_src = '0;
        addr = '0; bus_b = '0;
        valid_z = 1'b0; wr_rd_z = 1'b0; wr_src_z = '0; rd_src_z = '0; addr_z = '0; bus_b_z = '0;
        model_clear();
        rd_m = '0;

        repeat (2) @(negedge clk);
        chk("reset_mem_rd", mem_rd, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_mis", mis, 0);
        chk_dbg("reset_dbg", dbg);
        rst = 1'b0;
        @(negedge clk);

        do_access(1'b1, 2'd0, 3'd0, 32'h08, 32'hDEAD_BEEF, "t1_sw", 1'b0);
        do_access(1'b0, 2'd0, 3'd0, 32'h08, 32'h0, "t1_lw", 1'b0);
        chk("t1_rd", mem_rd, 32'hDEAD_BEEF);
        chk("t1_dbg_w2", dbg[95:64], 32'hDEAD_BEEF);

        do_access(1'b1, 2'd2, 3'd0, 32'h09, 32'h7F5A, "t2_sb", 1'b0);
        chk("t2_dbg_w2", dbg[95:64], 32'hDEAD_5AEF);
        do_access(1'b0, 2'd0, 3'd2, 32'h0B, 32'h0, "t2_lb", 1'b0);
        chk("t2_lb_rd", mem_rd, 32'hFFFF_FFDE);
        do_access(1'b0, 2'd0, 3'd4, 32'h0B, 32'h0, "t2_lbu", 1'b0);
        chk("t2_lbu_rd", mem_rd, 32'h0000_00DE);

        do_access(1'b1, 2'd0, 3'd0, 32'h0C, 32'h1122_3344, "t3_sw", 1'b0);
        do_access(1'b1, 2'd1, 3'd0, 32'h0E, 32'h0000_8001, "t3_sh", 1'b0);
        chk("t3_dbg_w3", dbg[127:96], 32'h8001_3344);
        do_access(1'b0, 2'd0, 3'd1, 32'h0E, 32'h0, "t3_lh", 1'b0);
        chk("t3_lh_rd", mem_rd, 32'hFFFF_8001);
        do_access(1'b0, 2'd0, 3'd3, 32'h0E, 32'h0, "t3_lhu", 1'b0);
        chk("t3_lhu_rd", mem_rd, 32'h0000_8001);

        do_access(1'b0, 2'd0, 3'd0, 32'h06, 32'h0, "t4_lw_mis", 1'b0);
        do_access(1'b1, 2'd1, 3'd0, 32'h05, 32'hAAAA_5555, "t4_sh_mis", 1'b0);
        do_access(1'b0, 2'd0, 3'd1, 32'h03, 32'h0, "t4_lh_mis", 1'b0);
        chk("t4_rd_kept", mem_rd, 32'h0000_8001);

        do_access(1'b1, 2'd0, 3'd0, 32'h20, 32'hCAFE_F00D, "t5_intrude", 1'b1);
        repeat (3) @(negedge clk);

        for (int n = 0; n < 80; n++) begin
            ra = $urandom;
            if ($urandom_range(0, 2) == 0) ra[1:0] = 2'b00;
            do_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                      ra, $urandom, "rand", 1'b0);
        end

        valid = 1'b1; wr_rd = 1'b1; wr_src = 2'd0; addr = 32'h14; bus_b = 32'h5A5A_A5A5;
        @(posedge clk);
        #1 valid = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        model_clear();
        chk("t5_flush_busy", busy, 0);
        chk_dbg("t5_flush_dbg", dbg);
        repeat (5) @(negedge clk);

        rd = $urandom | 32'h1;
        do_access(1'b1, 2'd0, 3'd0, 32'h1C, rd, "post_flush_sw", 1'b0);
        do_access(1'b0, 2'd0, 3'd0, 32'h1C, 32'h0, "post_flush_lw", 1'b0);
        do_access(1'b0, 2'd0, 3'd0, 32'h08, 32'h0, "post_flush_lw0", 1'b0);

        for (int i = 0; i < 3; i++) d6[i] = $urandom;
        for (int k = 0; k < 10; k++) begin
            valid_z = 1'b1; wr_rd_z = ((k/2) % 2) == 0; wr_src_z = 2'd0; rd_src_z = 3'd0;
            addr_z = 32'h10; bus_b_z = d6[k/4];
            @(negedge clk);
        end
        valid_z = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_done_count", done_z_cnt, 5);
        chk("t6_load1", got_z[1], d6[0]);
        chk("t6_load2", got_z[3], d6[1]);
        chk("t6_dbg_w4", dbg_z[159:128], d6[2]);
        chk("t6_mis", mis_z, 0);

        do_access(1'b1, 2'd0, 3'd0, 32'h08, 32'h0BAD_F00D, "pre_reset_sw", 1'b0);
        do_access(1'b0, 2'd0, 3'd0, 32'h08, 32'h0, "pre_reset_lw", 1'b0);
        valid = 1'b1; wr_rd = 1'b0; rd_src = 3'd0; addr = 32'h08;
        @(posedge clk);
        #1 valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_clear();
        rd_m = '0;
        chk("t5_rst_mem_rd", mem_rd, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_done", done, 0);
        chk("t5_rst_mis", mis, 0);
        chk_dbg("t5_rst_dbg", dbg);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_access(1'b0, 2'd0, 3'd0, 32'h08, 32'h0, "post_reset_lw", 1'b0);
        chk("post_reset_rd", mem_rd, 0);

        repeat (4) @(negedge clk);
        chk("exp_q_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
